// File: rtl/write_reg_bank.sv
// Result register bank: one-hot addressed fill of DEPTH signed words, then an
// in-order ReLU drain over a valid/ready stream once every entry has been written.
module write_reg_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 15,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DEPTH-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              full,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   fill_q, fill_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic               sel_onehot;
    logic               wr_ok;
    logic [DATA_W-1:0]  entry_w [DEPTH];
    logic [DATA_W-1:0]  rd_word;

    // A select is legal only with exactly one bit set.
    assign sel_onehot = (wr_sel != '0) && ((wr_sel & (wr_sel - DEPTH'(1))) == '0);
    assign wr_ok      = wr_en && sel_onehot && (state_q == ST_FILL) && !clear;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (clear) begin
            state_d = ST_FILL;
            fill_d  = '0;
            idx_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (wr_en) begin
                        if (sel_onehot) begin
                            fill_d = fill_q | wr_sel;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    // Decision uses the registered full; a same-cycle write still lands.
                    if (rd_start && full) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                    end
                end
                ST_DRAIN: begin
                    if (wr_en) begin
                        err_d = 1'b1;
                    end
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_FILL;
                            fill_d  = '0;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] word_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else if (wr_ok && wr_sel[gi]) begin
                    word_q <= wr_data;
                end
            end
            assign entry_w[gi] = word_q;
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rd_word = entry_w[i];
            end
        end
    end

    assign out_valid = (state_q == ST_DRAIN);
    assign busy      = (state_q == ST_DRAIN);
    assign out_idx   = idx_q;
    assign out_last  = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);
    assign out_data  = rd_word[DATA_W-1] ? '0 : rd_word;
    assign full      = &fill_q;
    assign err       = err_q;

endmodule

// File: doc/write_reg_bank.md
Name: write_reg_bank

Overview:
15-entry register bank for convolution results, addressed by a one-hot write select from the upstream write-address ring counter (reset select = bit 14, rotating left each enabled write).
- Tracks which entries hold valid data and asserts full once all 15 are written.
- On command, drains entries 0..14 in order over a valid/ready stream, with ReLU applied, toward the next layer stage.

Parameters:
DATA_W, 16, width of each signed (two's complement) result word
DEPTH, 15, number of entries; must equal the one-hot select width
IDX_W, 4, width of out_idx; must satisfy 2^IDX_W >= DEPTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of fill map, error flag and FSM
wr_en  in  1  write strobe for the current result
wr_sel  in  DEPTH  one-hot entry select; bit k writes entry k
wr_data  in  DATA_W  signed result word to store
rd_start  in  1  request to begin draining; honoured only when full
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts word when high with out_valid
out_data  out  DATA_W  ReLU(entry[out_idx]): negative values output as 0
out_idx  out  IDX_W  entry index currently presented
out_last  out  1  high with out_valid when out_idx == DEPTH-1
full  out  1  all DEPTH fill bits set
busy  out  1  high in DRAIN
err  out  1  sticky: non-one-hot write attempt or write during DRAIN

Behaviour:
- Reset (async, rst_n=0):
  - fill map = 0; state = FILL; out_idx = 0.
  - out_valid, out_last, full, busy, err all = 0.
  - Entry contents are reset to 0.
- States: FILL, DRAIN.
- FILL, wr_en=1 and wr_sel exactly one-hot (bit k):
  - entry[k] <= wr_data and fill[k] <= 1 at the next edge.
  - Overwriting an already-filled entry is legal; the last value wins.
- FILL, wr_en=1 and wr_sel zero or multi-hot:
  - No entry is written and the fill map is unchanged.
  - err <= 1 and stays set until clear or reset.
- full = AND of fill map, driven combinationally from registers.
  - The cycle after the 15th distinct entry is written, full = 1.
- rd_start=1 in FILL with full=1 (registered value at the edge):
  - Go to DRAIN with out_idx = 0.
  - A write in that same cycle is still performed.
  - DRAIN presents the updated data.
- rd_start with full=0, or while already in DRAIN: ignored, no error.
- DRAIN:
  - out_valid = 1 and busy = 1.
  - out_data is combinational from registered out_idx and the entry registers.
  - On out_valid & out_ready: out_idx increments at the next edge.
  - Without out_ready: out_idx, out_data and out_last hold stable.
- Accept with out_last=1:
  - Next edge: state = FILL, fill map = 0, out_idx = 0, out_valid = 0.
  - Entry contents are retained.
- wr_en=1 during DRAIN: write dropped, err <= 1.
- Throughput: one word per cycle with out_ready held high.
  - 15 words accepted in 15 consecutive cycles starting the cycle after rd_start.
- ReLU: if entry MSB = 1, out_data = 0; else out_data = entry unchanged. No saturation or shift.
- clear=1:
  - Priority over all other inputs at that edge.
  - Fill map = 0, err = 0, state = FILL, out_idx = 0, out_valid = 0; entries retained.
- Reset asserted mid-DRAIN: immediately returns to reset values. No partial-stream recovery.

Test Plan:
- Reset, then 15 writes with wr_sel rotating 0x4000, 0x0001, 0x0002, …, 0x2000 and data = k-7 for entry k -> full=1 the cycle after the last write; err=0.
- rd_start with out_ready=1 -> out_idx 0..14 on 15 consecutive cycles; out_data = 0 for idx 0..7 and 1..7 for idx 8..14; out_last only at idx 14; next cycle out_valid=0, full=0.
- Same drain with out_ready toggled 1,0,0,1,… -> out_data/out_idx held while out_ready=0; all 15 words delivered exactly once, in order.
- wr_en with wr_sel=0x0003, then with 0x0000 -> no fill bit changes; err=1 sticky; clear -> err=0.
- 14 entries filled, rd_start -> stays FILL, busy=0; write entry 5 twice (0x0010 then 0x7FFF) plus the missing entry, then drain -> idx 5 outputs 0x7FFF.
- rst_n=0 at drain idx 6 -> out_valid, busy, full, err = 0 asynchronously; after release, rd_start ignored until 15 new writes.
